// File: rtl/cmos_capture_pack.sv
// Purpose: DVP camera capture front end. Discards the first WAIT_FRAME frames, gates capture per frame, packs bytes into pixels with x/y coordinates.
// Latency: a byte registered into the first input stage appears as a packed pixel one pclk later.
// Backpressure: none. The sensor cannot be stalled, so downstream logic must accept every valid strobe.
module cmos_capture_pack #(
    parameter int DW         = 8,
    parameter int PACK       = 2,
    parameter int WAIT_FRAME = 10,
    parameter int XW         = 12,
    parameter int YW         = 12
) (
    input  logic                 cam_pclk,
    input  logic                 rst_n,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic [DW-1:0]        cam_data,
    input  logic                 cap_en,
    input  logic                 byte_swap,
    output logic                 cmos_frame_vsync,
    output logic                 cmos_frame_href,
    output logic                 cmos_frame_valid,
    output logic [DW*PACK-1:0]   cmos_frame_data,
    output logic [XW-1:0]        pix_x,
    output logic [YW-1:0]        pix_y,
    output logic                 frame_done,
    output logic                 line_err,
    output logic [7:0]           frame_cnt
);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_CAP, S_SKIP} state_t;

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_FRAME);
    localparam bit         SINGLE   = (PACK == 1);

    state_t               state, state_nxt;
    logic [3:0]           wait_cnt, wait_cnt_nxt;
    logic                 vs_d0, vs_d1, hs_d0, hs_d1;
    logic [DW-1:0]        data_d0;
    logic [DW-1:0]        hold;
    logic                 phase;
    logic [XW-1:0]        x_cnt;
    logic [YW-1:0]        y_cnt;
    logic                 line_has_pix;
    logic                 pos_vs, neg_vs, neg_hs;
    logic                 in_cap, emit, frame_done_nxt;
    logic [DW*PACK-1:0]   word;

    assign pos_vs = vs_d0 & ~vs_d1;
    assign neg_vs = ~vs_d0 & vs_d1;
    assign neg_hs = ~hs_d0 & hs_d1;
    assign in_cap = (state == S_CAP);
    // A pixel completes on every byte (PACK=1) or on the second byte of a pair.
    assign emit   = in_cap & hs_d0 & (SINGLE | phase);

    generate
        if (PACK == 1) begin : g_pack1
            assign word = data_d0;
        end else begin : g_pack2
            assign word = byte_swap ? {data_d0, hold} : {hold, data_d0};
        end
    endgenerate

    // Framing outputs follow the second sync stage so they line up with the packed data.
    assign cmos_frame_vsync = vs_d1 & in_cap;
    assign cmos_frame_href  = hs_d1 & in_cap;

    // Two-stage input registers; the pixel output register serves as the second data stage.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0   <= 1'b0;
            vs_d1   <= 1'b0;
            hs_d0   <= 1'b0;
            hs_d1   <= 1'b0;
            data_d0 <= '0;
        end else begin
            vs_d0   <= cam_vsync;
            vs_d1   <= vs_d0;
            hs_d0   <= cam_href;
            hs_d1   <= hs_d0;
            data_d0 <= cam_data;
        end
    end

    // Frame state register and settle-frame counter.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic: a vsync rise in any post-settle state starts a new frame decided by cap_en.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        frame_done_nxt = 1'b0;
        case (state)
            S_WAIT: begin
                if (pos_vs) begin
                    if (wait_cnt < WAIT_LIM) wait_cnt_nxt = wait_cnt + 1'b1;
                    else                     state_nxt    = cap_en ? S_CAP : S_SKIP;
                end
            end
            S_IDLE: begin
                if (pos_vs) state_nxt = cap_en ? S_CAP : S_SKIP;
            end
            S_CAP: begin
                if (pos_vs) begin
                    state_nxt = cap_en ? S_CAP : S_SKIP;
                end else if (neg_vs) begin
                    state_nxt      = S_IDLE;
                    frame_done_nxt = 1'b1;
                end
            end
            S_SKIP: begin
                if (pos_vs)      state_nxt = cap_en ? S_CAP : S_SKIP;
                else if (neg_vs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // Byte pairing and per-line bookkeeping; everything restarts whenever href is low.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= 1'b0;
            hold         <= '0;
            x_cnt        <= '0;
            line_has_pix <= 1'b0;
        end else begin
            if (!hs_d0 || !in_cap) phase <= 1'b0;
            else if (!SINGLE)      phase <= ~phase;
            if (in_cap && hs_d0 && !phase) hold <= data_d0;
            if (!hs_d0) begin
                x_cnt        <= '0;
                line_has_pix <= 1'b0;
            end else if (emit) begin
                line_has_pix <= 1'b1;
                if (x_cnt != '1) x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // Row counter: restarts at frame start, advances only after lines that produced pixels.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            y_cnt <= '0;
        end else if (pos_vs) begin
            y_cnt <= '0;
        end else if (in_cap && neg_hs && line_has_pix && y_cnt != '1) begin
            y_cnt <= y_cnt + 1'b1;
        end
    end

    // Registered pixel, coordinate and event outputs.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cmos_frame_valid <= 1'b0;
            cmos_frame_data  <= '0;
            pix_x            <= '0;
            pix_y            <= '0;
            frame_done       <= 1'b0;
            line_err         <= 1'b0;
            frame_cnt        <= '0;
        end else begin
            cmos_frame_valid <= emit;
            if (emit) begin
                cmos_frame_data <= word;
                pix_x           <= x_cnt;
                pix_y           <= y_cnt;
            end
            frame_done <= frame_done_nxt;
            line_err   <= in_cap & neg_hs & ~SINGLE & phase;
            if (frame_done_nxt) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmos_capture_pack.sv
module tb_cmos_capture_pack;

    logic        cam_pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        cap_en = 1'b0;
    logic        byte_swap = 1'b0;
    logic        cmos_frame_vsync, cmos_frame_href, cmos_frame_valid;
    logic [15:0] cmos_frame_data;
    logic [11:0] pix_x, pix_y;
    logic        frame_done, line_err;
    logic [7:0]  frame_cnt;

    cmos_capture_pack #(.DW(8), .PACK(2), .WAIT_FRAME(10), .XW(12), .YW(12)) dut (
        .cam_pclk(cam_pclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cap_en(cap_en), .byte_swap(byte_swap),
        .cmos_frame_vsync(cmos_frame_vsync), .cmos_frame_href(cmos_frame_href),
        .cmos_frame_valid(cmos_frame_valid), .cmos_frame_data(cmos_frame_data),
        .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .line_err(line_err),
        .frame_cnt(frame_cnt)
    );

    always #5 cam_pclk = ~cam_pclk;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
    } pix_t;

    pix_t pq[$];
    int   lq[$];
    int   fq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_fc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected at %0t", name, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vsync"}, cmos_frame_vsync, 0);
        chk({tag, "_href"},  cmos_frame_href, 0);
        chk({tag, "_valid"}, cmos_frame_valid, 0);
        chk({tag, "_data"},  cmos_frame_data, 0);
        chk({tag, "_pix_x"}, pix_x, 0);
        chk({tag, "_pix_y"}, pix_y, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_line_err"}, line_err, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // Line l byte i: 0x12,0x34,0x56,0x78,... offset by the line number.
    function automatic logic [7:0] bval(input int l, input int i);
        return 8'(18 + l + i * 34);
    endfunction

    // One sensor frame; expectations pushed up front when the frame should be captured.
    task automatic send_frame(input int nl, input int nb, input bit exp_cap,
                              input bit auto_exp, input bit cap_mid);
        if (exp_cap) begin
            if (auto_exp) begin
                for (int l = 0; l < nl; l++) begin
                    for (int p = 0; p < nb / 2; p++) begin
                        logic [7:0] hi, lo;
                        hi = bval(l, 2 * p);
                        lo = bval(l, 2 * p + 1);
                        pq.push_back('{byte_swap ? {lo, hi} : {hi, lo}, p, l});
                    end
                    if (nb % 2 == 1) lq.push_back(l);
                end
            end
            exp_fc++;
            fq.push_back(exp_fc);
        end
        cam_vsync = 1'b1;
        repeat (5) @(negedge cam_pclk);
        for (int l = 0; l < nl; l++) begin
            for (int i = 0; i < nb; i++) begin
                cam_href = 1'b1;
                cam_data = bval(l, i);
                @(negedge cam_pclk);
            end
            cam_href = 1'b0;
            cam_data = 8'h00;
            if (l == 0) cap_en = cap_mid;
            repeat (3) @(negedge cam_pclk);
        end
        cam_vsync = 1'b0;
        repeat (4) @(negedge cam_pclk);
    endtask

    // Monitor: pops expectations whenever the DUT presents a pixel or an event pulse.
    always @(posedge cam_pclk) begin
        pix_t p;
        #1;
        if (rst_n) begin
            if (cmos_frame_valid) begin
                if (pq.size() == 0) unexpected("valid");
                else begin
                    p = pq.pop_front();
                    chk("pix_data", cmos_frame_data, p.d);
                    chk("pix_x", pix_x, p.x);
                    chk("pix_y", pix_y, p.y);
                    chk("pix_href_vsync", {cmos_frame_href, cmos_frame_vsync}, 2'b11);
                end
            end
            if (line_err) begin
                if (lq.size() == 0) unexpected("line_err");
                else chk("line_err_row", pix_y, lq.pop_front());
            end
            if (frame_done) begin
                if (fq.size() == 0) unexpected("frame_done");
                else chk("frame_done_cnt", frame_cnt, fq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge cam_pclk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge cam_pclk);

        // Settle frames: nothing may come out.
        cap_en = 1'b1;
        byte_swap = 1'b0;
        repeat (10) send_frame(2, 4, 0, 1, 1);

        // First captured frames with hand-computed pixels.
        pq.push_back('{16'h1234, 0, 0});
        pq.push_back('{16'h5678, 1, 0});
        send_frame(1, 4, 1, 0, 1);
        byte_swap = 1'b1;
        pq.push_back('{16'h3412, 0, 0});
        pq.push_back('{16'h7856, 1, 0});
        send_frame(1, 4, 1, 0, 1);
        chk("frame_cnt_after_12", frame_cnt, 2);

        // Odd-length lines: two pixels per line plus a line error each.
        byte_swap = 1'b0;
        send_frame(3, 5, 1, 1, 1);

        // cap_en low at frame start, raised mid-frame: frame skipped.
        cap_en = 1'b0;
        send_frame(2, 4, 0, 1, 1);
        // Captured; cap_en dropped mid-frame does not truncate it.
        send_frame(2, 4, 1, 1, 0);
        // Following frame skipped; cap_en restored mid-frame.
        send_frame(2, 4, 0, 1, 1);
        chk("frame_cnt_after_gating", frame_cnt, 4);

        // Reset in the middle of a captured line.
        pq.push_back('{16'h1234, 0, 0});
        cam_vsync = 1'b1;
        repeat (5) @(negedge cam_pclk);
        cam_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cam_data = bval(0, i);
            @(negedge cam_pclk);
        end
        #2 rst_n = 1'b0;
        #1 chk_zero("midline_reset");
        cam_href = 1'b0;
        cam_vsync = 1'b0;
        cam_data = 8'h00;
        @(negedge cam_pclk);
        rst_n = 1'b1;
        exp_fc = 0;
        repeat (3) @(negedge cam_pclk);
        chk("pixels_pending_after_reset", pq.size(), 0);

        // Settle sequence runs again, then one captured frame.
        repeat (10) send_frame(1, 4, 0, 1, 1);
        send_frame(2, 6, 1, 1, 1);

        repeat (5) @(negedge cam_pclk);
        chk("frame_cnt_final", frame_cnt, 1);
        chk("pix_queue_empty", pq.size(), 0);
        chk("line_err_queue_empty", lq.size(), 0);
        chk("frame_done_queue_empty", fq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmos_capture_pack.md
# cmos_capture_pack

Parametrised DVP camera capture front end that sits between the sensor pins and the line buffer / FIFO write logic. It discards the first WAIT_FRAME frames after reset so that register settings can settle, gates capture per frame with an enable, and packs PACK bytes into one pixel word. It also emits per-pixel x/y coordinates, an end-of-frame pulse and a line-length error pulse. All logic runs in the camera pixel clock domain.

## Interface
Parameters:
- DW, default 8: sensor data bus width.
- PACK, default 2: bytes per output pixel, legal values 1 or 2.
- WAIT_FRAME, default 10: number of frames (1..15) discarded after reset.
- XW, default 12: width of pix_x.
- YW, default 12: width of pix_y.

Ports:
- cam_pclk, in, 1: pixel clock; all logic on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- cam_vsync, in, 1: frame valid, active high.
- cam_href, in, 1: line valid, active high.
- cam_data, in, DW: sensor byte.
- cap_en, in, 1: capture enable, sampled at frame start.
- byte_swap, in, 1: 0 = first byte is MSB; 1 = first byte is LSB (ignored when PACK=1).
- cmos_frame_vsync, out, 1: delayed vsync, high only in captured frames.
- cmos_frame_href, out, 1: delayed href, high only in captured frames.
- cmos_frame_valid, out, 1: one-cycle strobe per packed pixel.
- cmos_frame_data, out, DW*PACK: packed pixel, held until the next strobe.
- pix_x, out, XW: column of the current pixel, 0-based.
- pix_y, out, YW: row of the current pixel, 0-based.
- frame_done, out, 1: one-cycle pulse at the end of a captured frame.
- line_err, out, 1: one-cycle pulse when a line ends with an incomplete pixel.
- frame_cnt, out, 8: number of captured frames, wraps from 255 to 0.

## Operation
- Input stage: two register levels, d0 and d1, for vsync, href and data.
  - pos_vs = vs_d0 & ~vs_d1.
  - neg_vs = ~vs_d0 & vs_d1.
  - neg_hs = ~hs_d0 & hs_d1.
- Frame state machine, reset state S_WAIT:
  - S_WAIT: on pos_vs with wait_cnt < WAIT_FRAME, increment wait_cnt; the frame is discarded. On pos_vs with wait_cnt == WAIT_FRAME, go to S_CAP if cap_en=1, otherwise to S_SKIP. The first captured frame is therefore frame WAIT_FRAME+1.
  - S_IDLE: on pos_vs, go to S_CAP if cap_en=1, otherwise to S_SKIP.
  - S_CAP: on neg_vs, pulse frame_done, increment frame_cnt, go to S_IDLE. Deasserting cap_en mid-frame does not truncate the frame.
  - S_SKIP: on neg_vs, go to S_IDLE. No outputs are asserted.
  - pos_vs seen in S_CAP or S_SKIP (vsync glitch or missed fall): treat as a new frame start with the same rule as S_IDLE. No frame_done is issued.
- Packing, S_CAP only, driven by hs_d0:
  - A byte phase register is cleared while hs_d0=0.
  - PACK=1: every byte produces a pixel.
  - PACK=2: phase 0 latches the byte into hold and sets phase to 1. Phase 1 emits byte_swap ? {byte, hold} : {hold, byte} and clears phase.
- Coordinates:
  - pix_x is the index of the emitted pixel. It resets to 0 at line start and saturates at 2^XW-1.
  - pix_y resets to 0 at frame start. It increments on neg_hs when the line emitted at least one pixel, and saturates at 2^YW-1.
- line_err: pulses on neg_hs in S_CAP when PACK=2 and phase=1. The odd byte is discarded and no pixel is emitted.
- A line cut by vsync falling is handled as a normal line end (line_err rule applies), then frame_done follows.
- Data outside S_CAP is dropped. Data in the two cycles before the state update at pos_vs is not captured; the sensor guarantees at least 4 pclk between the vsync rise and the first href.

## Timing
- Reset: all outputs 0. State S_WAIT, wait_cnt=0, phase=0, hold=0.
- Asserting rst_n mid-frame restarts the whole sequence, including the WAIT_FRAME skip.
- Latency: a byte sampled into d0 at edge k. If it completes a pixel, cmos_frame_valid, cmos_frame_data, pix_x and pix_y update at edge k+1.
- cmos_frame_vsync and cmos_frame_href equal vs_d1 and hs_d1 gated by state==S_CAP, so they align with data.
- frame_done and line_err are registered and assert at the edge after neg_vs or neg_hs is detected.
- When PACK=2, valid strobes are never in consecutive cycles; the minimum spacing is 2 pclk.

## Test plan
- Reset, then 12 frames, cap_en=1, WAIT_FRAME=10 -> no valid during frames 1–10. Frames 11 and 12 captured; frame_cnt=2 and two frame_done pulses.
- PACK=2, byte_swap=0, line bytes 0x12,0x34,0x56,0x78 -> data 0x1234 with pix_x=0, then 0x5678 with pix_x=1. With byte_swap=1 -> 0x3412, then 0x7856.
- 3 lines of 5 bytes, PACK=2 -> 2 pixels per line and line_err pulses 3 times; pix_y takes 0,1,2.
- cap_en=0 at a frame start, set to 1 mid-frame -> that frame produces nothing; the next frame is captured.
- cap_en dropped mid-capture -> the frame completes, frame_done pulses, the following frame is skipped.
- rst_n asserted mid-line in a captured frame -> all outputs 0 immediately; the next 10 frames are discarded again.
